pe_mac_tree: RTL and testbench
==============================

PE_MAC_TREE -- requirements
Module: pe_mac_tree

Interface
REQ-001 Parameters: NOC_WID, default 16, data word width; ADDR_WID, default 11, config address width; NCHILD, default 2, child ports (legal 1..4).
REQ-002 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  config write strobe.
- cfg_adr  in  ADDR_WID  config address.
- cfg_dat  in  NOC_WID  config write data.
- slv_addr  in  ADDR_WID  this PE's base address.
- in_valid  in  1  operand from parent is valid.
- in_data  in  NOC_WID  signed operand.
- in_ready  out  1  operand accept.
- dn_valid  out  NCHILD  operand broadcast to each child.
- dn_data  out  NCHILD*NOC_WID  broadcast operand.
- dn_ready  in  NCHILD  per-child accept.
- cs_valid  in  NCHILD  child partial sum valid.
- cs_data  in  NCHILD*2*NOC_WID  child partial sums, signed.
- cs_ready  out  NCHILD  per-child partial-sum accept.
- up_valid  out  1  result valid to parent.
- up_data  out  2*NOC_WID  signed result.
- up_ready  in  1  parent accept.

Function
REQ-003 Transfer on any channel: valid & ready on a rising clk edge; valid and data are held until that edge.
REQ-004 Config write: cfg_we high and cfg_adr == slv_addr writes WEIGHT (signed NOC_WID); cfg_adr == slv_addr+1 writes MASK (cfg_dat[NCHILD-1:0], child enable); other addresses are ignored.
REQ-005 Config writes take effect the next cycle in any state; the operation in flight keeps the WEIGHT and MASK latched at operand accept.
REQ-006 FSM states: IDLE, FWD, SEND.
- in_ready = 1 only in IDLE.
- Operand accept in IDLE latches P = in_data*WEIGHT (signed, full 2*NOC_WID) and MASK.
- Next state is FWD if latched MASK != 0, else SEND.
REQ-007 FWD, per child i:
- dn_valid[i] = MASK[i] & !sent[i]; sent[i] sets on dn handshake.
- cs_ready[i] = MASK[i] & !rcvd[i]; rcvd[i] sets on cs handshake.
- Each cs_data[i] accepted is added to the accumulator.
REQ-008 A child's forward and sum handshakes may complete in the same cycle, and in any order relative to each other and to other children; all are honoured.
REQ-009 FWD -> SEND on the edge where every enabled child has both sent and rcvd set, including ones set that edge.
REQ-010 SEND: up_valid = 1 and up_data = P + Σ accepted child sums. On the up_ready handshake: clear sent/rcvd, go to IDLE. The first operand accept is possible the following cycle.
REQ-011 Minimum latency, operand accept to up_valid: 1 cycle in leaf mode (MASK = 0); 2 cycles with children that accept immediately.
REQ-012 Outputs outside their active state: dn_valid 0, cs_ready 0, up_valid 0. dn_data always carries the latched operand.
REQ-013 Arithmetic is two's complement, 2*NOC_WID wide, with overflow handled per REQ-017.

Reset
REQ-014 rstn low forces state IDLE immediately, without waiting for clk, and aborts any operation in flight.
REQ-015 Values while rstn is low:
- WEIGHT 0; MASK all ones; accumulator, P, sent, rcvd 0.
- dn_valid 0, cs_ready 0, up_valid 0, up_data 0, dn_data 0.
- in_ready 1.
REQ-016 After rstn releases, the first operand accept happens on the first clk edge with in_valid high.

Configuration
REQ-017 Macro PE_SAT_EN:
- Defined: each addition into the accumulator saturates to [-2^(2*NOC_WID-1), 2^(2*NOC_WID-1)-1].
- Undefined: each addition wraps modulo 2^(2*NOC_WID).

Verification
REQ-018 The bench runs with NOC_WID=16 and NCHILD=2, and covers these scenarios:
- Base case: WEIGHT=3, MASK=0b11, in_data=5, child sums 100 and 200 -> up_data=315 (0x13B).
- Leaf mode: MASK=0, WEIGHT=0xFFFE (-2), in_data=7 -> up_valid one cycle after accept, up_data=0xFFFFFFF2, dn_valid stays 0.
- Backpressure: dn_ready[1] low for 10 cycles, sum 1 arrives before its forward completes, up_ready low for 3 cycles -> dn_valid[1] and up_valid/up_data held stable, in_ready low until the SEND handshake, up_data correct.
- Overflow: WEIGHT=0x7FFF, in_data=0x7FFF, sums 0x7FFFFFFF and 1 -> up_data=0x7FFFFFFF with PE_SAT_EN defined, 0xBFFF0001 without it.
- Reset and config: rstn pulsed low mid-FWD, then a fresh operation -> outputs return to reset values with no clk edge needed, next result uses reset WEIGHT=0 (result = child sums only); a WEIGHT write during FWD does not change the in-flight result.

Source files
------------

// File: rtl/pe_mac_tree.sv
// pe_mac_tree: one processing element of a broadcast/reduce MAC tree.
// An operand from the parent is multiplied by a local WEIGHT, broadcast to
// the enabled children, and their partial sums are added to the product
// before the total is returned upward.
// Optional feature macro: PE_SAT_EN -- when defined, every addition into the
// accumulator saturates to the signed 2*NOC_WID range; otherwise it wraps.
module pe_mac_tree #(
    parameter int NOC_WID  = 16,
    parameter int ADDR_WID = 11,
    parameter int NCHILD   = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cfg_we,
    input  logic [ADDR_WID-1:0]           cfg_adr,
    input  logic [NOC_WID-1:0]            cfg_dat,
    input  logic [ADDR_WID-1:0]           slv_addr,
    input  logic                          in_valid,
    input  logic [NOC_WID-1:0]            in_data,
    output logic                          in_ready,
    output logic [NCHILD-1:0]             dn_valid,
    output logic [NCHILD*NOC_WID-1:0]     dn_data,
    input  logic [NCHILD-1:0]             dn_ready,
    input  logic [NCHILD-1:0]             cs_valid,
    input  logic [NCHILD*2*NOC_WID-1:0]   cs_data,
    output logic [NCHILD-1:0]             cs_ready,
    output logic                          up_valid,
    output logic [2*NOC_WID-1:0]          up_data,
    input  logic                          up_ready
);

    localparam int AW = 2 * NOC_WID;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    // Architectural state
    state_t                      r_state;
    state_t                      w_state_nxt;
    logic signed [NOC_WID-1:0]   r_weight;   // configured weight
    logic [NCHILD-1:0]           r_mask;     // configured child enable
    logic [NCHILD-1:0]           r_lmask;    // mask latched for the op in flight
    logic [NOC_WID-1:0]          r_op;       // operand latched for broadcast
    logic signed [AW-1:0]        r_acc;      // product plus child sums so far
    logic [NCHILD-1:0]           r_sent;
    logic [NCHILD-1:0]           r_rcvd;

    // Combinational helpers
    logic [ADDR_WID-1:0]         w_adr_p1;
    logic                        w_wr_weight;
    logic                        w_wr_mask;
    logic                        w_accept;
    logic                        w_up_hs;
    logic [NCHILD-1:0]           w_dn_hs;
    logic [NCHILD-1:0]           w_cs_hs;
    logic [NCHILD-1:0]           w_sent_nxt;
    logic [NCHILD-1:0]           w_rcvd_nxt;
    logic                        w_all_done;
    logic signed [AW-1:0]        w_prod;
    logic signed [AW-1:0]        w_acc_sum;

    // Single accumulator addition; saturating or wrapping depending on build.
    function automatic logic signed [AW-1:0] acc_add(
        input logic signed [AW-1:0] a,
        input logic signed [AW-1:0] b
    );
`ifdef PE_SAT_EN
        logic [AW:0] s;
        s = {a[AW-1], a} + {b[AW-1], b};
        if (s[AW] != s[AW-1])
            return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        return s[AW-1:0];
`else
        return a + b;
`endif
    endfunction

    assign w_adr_p1    = slv_addr + ADDR_WID'(1);
    assign w_wr_weight = cfg_we && (cfg_adr == slv_addr);
    assign w_wr_mask   = cfg_we && (cfg_adr == w_adr_p1);
    assign w_accept    = (r_state == S_IDLE) && in_valid;
    assign w_up_hs     = (r_state == S_SEND) && up_ready;
    assign w_prod      = $signed(in_data) * r_weight;

    // Broadcast data always reflects the latched operand, one copy per child.
    for (genvar g = 0; g < NCHILD; g++) begin : g_dn
        assign dn_data[g*NOC_WID +: NOC_WID] = r_op;
    end

    // Handshake outputs are only asserted in their owning state.
    always_comb begin
        in_ready = (r_state == S_IDLE);
        dn_valid = '0;
        cs_ready = '0;
        up_valid = 1'b0;
        if (r_state == S_FWD) begin
            dn_valid = r_lmask & ~r_sent;
            cs_ready = r_lmask & ~r_rcvd;
        end
        if (r_state == S_SEND)
            up_valid = 1'b1;
        up_data = r_acc;
    end

    // Per-child handshake tracking, including handshakes on the current edge.
    always_comb begin
        w_dn_hs    = dn_valid & dn_ready;
        w_cs_hs    = cs_valid & cs_ready;
        w_sent_nxt = r_sent | w_dn_hs;
        w_rcvd_nxt = r_rcvd | w_cs_hs;
        w_all_done = ((r_lmask & ~(w_sent_nxt & w_rcvd_nxt)) == '0);
    end

    // Fold every child sum accepted this cycle into the accumulator in index order.
    always_comb begin
        w_acc_sum = r_acc;
        for (int i = 0; i < NCHILD; i++) begin
            if (w_cs_hs[i])
                w_acc_sum = acc_add(w_acc_sum, $signed(cs_data[i*AW +: AW]));
        end
    end

    // Next-state logic for the IDLE -> FWD/SEND -> IDLE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = (r_mask != '0) ? S_FWD : S_SEND;
            S_FWD:  if (w_all_done) w_state_nxt = S_SEND;
            S_SEND: if (up_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Configuration registers; writes land regardless of FSM state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_weight <= '0;
            r_mask   <= '1;
        end else begin
            if (w_wr_weight) r_weight <= cfg_dat;
            if (w_wr_mask)   r_mask   <= cfg_dat[NCHILD-1:0];
        end
    end

    // Datapath: latch operand/product/mask on accept, accumulate child sums.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op    <= '0;
            r_lmask <= '0;
            r_acc   <= '0;
            r_sent  <= '0;
            r_rcvd  <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= in_data;
                r_lmask <= r_mask;
                r_acc   <= w_prod;
                r_sent  <= '0;
                r_rcvd  <= '0;
            end else if (r_state == S_FWD) begin
                r_sent  <= w_sent_nxt;
                r_rcvd  <= w_rcvd_nxt;
                r_acc   <= w_acc_sum;
            end else if (w_up_hs) begin
                r_sent  <= '0;
                r_rcvd  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_tree.sv
// Self-checking bench for pe_mac_tree (NOC_WID=16, NCHILD=2): directed
// scenarios plus randomized operations against an integer reference model.
module tb_pe_mac_tree;

    localparam int NW = 16;
    localparam int AWD = 11;
    localparam int NC = 2;
    localparam logic [AWD-1:0] SLV = 11'h123;

    logic              clk, rstn;
    logic              cfg_we;
    logic [AWD-1:0]    cfg_adr;
    logic [NW-1:0]     cfg_dat;
    logic [AWD-1:0]    slv_addr;
    logic              in_valid, in_ready;
    logic [NW-1:0]     in_data;
    logic [NC-1:0]     dn_valid, dn_ready, cs_valid, cs_ready;
    logic [NC*NW-1:0]  dn_data;
    logic [NC*2*NW-1:0] cs_data;
    logic              up_valid, up_ready;
    logic [2*NW-1:0]   up_data;

    int n_chk = 0;
    int n_err = 0;

    // Reference configuration state
    logic [15:0] m_weight;
    logic [1:0]  m_mask;

    pe_mac_tree #(.NOC_WID(NW), .ADDR_WID(AWD), .NCHILD(NC)) dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_adr(cfg_adr), .cfg_dat(cfg_dat),
        .slv_addr(slv_addr), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dn_valid(dn_valid), .dn_data(dn_data), .dn_ready(dn_ready),
        .cs_valid(cs_valid), .cs_data(cs_data), .cs_ready(cs_ready),
        .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Result = signed product + enabled child sums, each addition wrapped or clamped.
    function automatic logic [31:0] model(input logic [15:0] din, input logic [15:0] w,
                                          input logic [1:0] m, input logic [31:0] s0,
                                          input logic [31:0] s1);
        longint acc;
        longint s [2];
        s[0] = longint'($signed(s0));
        s[1] = longint'($signed(s1));
        acc = longint'($signed(din)) * longint'($signed(w));
        for (int i = 0; i < 2; i++) begin
            if (m[i]) begin
                acc = acc + s[i];
`ifdef PE_SAT_EN
                if (acc > 64'sd2147483647) acc = 64'sd2147483647;
                if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
                acc = longint'($signed(acc[31:0]));
`endif
            end
        end
        return acc[31:0];
    endfunction

    task automatic cfg_write(input logic [AWD-1:0] adr, input logic [15:0] dat);
        @(negedge clk);
        cfg_we = 1'b1; cfg_adr = adr; cfg_dat = dat;
        @(negedge clk);
        cfg_we = 1'b0;
        if (adr == SLV) m_weight = dat;
        else if (adr == SLV + 11'd1) m_mask = dat[1:0];
    endtask

    // One complete operation with per-child delays; checks protocol and result.
    task automatic run_op(input string tag, input logic [15:0] din,
                          input logic [31:0] s0, input logic [31:0] s1,
                          input int dd0, input int dd1, input int dc0, input int dc1,
                          input int updly, input bit midw, input logic [15:0] midw_val,
                          output int lat);
        logic [31:0] exp, res, last_ud;
        logic [1:0]  en, dnd, csd, pv, pr;
        int ddl [2], cdl [2];
        int cyc, upc, v_ir, v_mask, v_dd, v_hold;
        bit done;
        ddl[0] = dd0; ddl[1] = dd1; cdl[0] = dc0; cdl[1] = dc1;
        en = m_mask;
        exp = model(din, m_weight, m_mask, s0, s1);
        dnd = '0; csd = '0; pv = '0; pr = '0;
        v_ir = 0; v_mask = 0; v_dd = 0; v_hold = 0; upc = 0; lat = -1;
        res = '0; last_ud = '0; done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = din; cs_data = {s1, s0};
        #1 chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < 300) begin
            if (midw && cyc == 0) begin
                cfg_we = 1'b1; cfg_adr = SLV; cfg_dat = midw_val;
            end else begin
                cfg_we = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                dn_ready[i] = (cyc >= ddl[i]);
                cs_valid[i] = en[i] && (cyc >= cdl[i]) && !csd[i];
            end
            up_ready = (upc >= updly);
            #1;
            if (!up_valid || !up_ready) begin
                if (in_ready) v_ir++;
            end
            for (int i = 0; i < 2; i++) begin
                if (!en[i] && dn_valid[i]) v_mask++;
                if (dn_valid[i] && dn_data[i*NW +: NW] != din) v_dd++;
                if (pv[i] && !pr[i] && !dn_valid[i]) v_hold++;
                if (dn_valid[i] && dn_ready[i]) dnd[i] = 1'b1;
                if (cs_valid[i] && cs_ready[i]) csd[i] = 1'b1;
                pv[i] = dn_valid[i];
                pr[i] = dn_ready[i];
            end
            if (up_valid) begin
                if (upc == 0) lat = cyc + 1;
                else if (up_data != last_ud) v_hold++;
                last_ud = up_data;
                upc++;
                if (up_ready) begin
                    res = up_data;
                    done = 1'b1;
                end
            end else if (upc > 0) begin
                v_hold++;
            end
            @(negedge clk);
            cyc++;
        end
        cfg_we = 1'b0; dn_ready = '0; cs_valid = '0; up_ready = 1'b0;
        if (midw) m_weight = midw_val;
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " result"}, 64'(res), 64'(exp));
        chk({tag, " protocol"}, 64'(v_ir + v_mask + v_dd + v_hold), 64'd0);
        chk({tag, " handshakes"}, 64'({dnd, csd}), 64'({en, en}));
        #1 chk({tag, " ready_after"}, 64'(in_ready), 64'd1);
    endtask

    int lat;

    initial begin
        rstn = 1'b0; cfg_we = 1'b0; cfg_adr = '0; cfg_dat = '0; slv_addr = SLV;
        in_valid = 1'b0; in_data = '0; dn_ready = '0; cs_valid = '0; cs_data = '0;
        up_ready = 1'b0;
        m_weight = 16'h0; m_mask = 2'b11;
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst outs", 64'({dn_valid, cs_ready, up_valid}), 64'd0);
        chk("rst up_data", 64'(up_data), 64'd0);
        chk("rst dn_data", 64'(dn_data), 64'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;

        // Base case
        cfg_write(SLV, 16'd3);
        cfg_write(SLV + 11'd1, 16'h0003);
        run_op("base", 16'd5, 32'd100, 32'd200, 0, 0, 0, 0, 0, 1'b0, 16'h0, lat);
        chk("base latency", 64'(lat), 64'd2);
        chk("base literal", 64'(model(16'd5, 16'd3, 2'b11, 32'd100, 32'd200)), 64'h13B);

        // Leaf mode
        cfg_write(SLV + 11'd1, 16'h0000);
        cfg_write(SLV, 16'hFFFE);
        run_op("leaf", 16'd7, 32'd11, 32'd22, 0, 0, 0, 0, 0, 1'b0, 16'h0, lat);
        chk("leaf latency", 64'(lat), 64'd1);
        chk("leaf literal", 64'(model(16'd7, 16'hFFFE, 2'b00, 32'd0, 32'd0)), 64'hFFFFFFF2);

        // Backpressure: child 1 forward late, its sum early, parent stalls 3 cycles
        cfg_write(SLV + 11'd1, 16'h0003);
        cfg_write(SLV, 16'd4);
        run_op("bp", 16'hFFF0, 32'd1000, 32'hFFFFFF00, 0, 10, 0, 0, 3, 1'b0, 16'h0, lat);

        // Overflow
        cfg_write(SLV, 16'h7FFF);
`ifdef PE_SAT_EN
        chk("ovf literal", 64'(model(16'h7FFF, 16'h7FFF, 2'b11, 32'h7FFFFFFF, 32'd1)), 64'h7FFFFFFF);
`else
        chk("ovf literal", 64'(model(16'h7FFF, 16'h7FFF, 2'b11, 32'h7FFFFFFF, 32'd1)), 64'hBFFF0001);
`endif
        run_op("ovf", 16'h7FFF, 32'h7FFFFFFF, 32'd1, 0, 1, 1, 0, 0, 1'b0, 16'h0, lat);

        // Weight write during FWD must not disturb the in-flight result
        cfg_write(SLV, 16'd2);
        run_op("midw", 16'd10, 32'd1, 32'd2, 3, 3, 3, 3, 0, 1'b1, 16'd50, lat);
        run_op("after_midw", 16'd10, 32'd1, 32'd2, 0, 0, 0, 0, 0, 1'b0, 16'h0, lat);

        // Write to an unrelated address is ignored
        cfg_write(SLV + 11'd2, 16'h0077);
        run_op("ignored", 16'd3, 32'd5, 32'd6, 1, 0, 0, 2, 1, 1'b0, 16'h0, lat);

        // Asynchronous reset in the middle of FWD
        cfg_write(SLV, 16'd9);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'd4;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("pre-rst dn_valid", 64'(dn_valid), 64'h3);
        #1 rstn = 1'b0;
        #1;
        chk("arst in_ready", 64'(in_ready), 64'd1);
        chk("arst outs", 64'({dn_valid, cs_ready, up_valid}), 64'd0);
        chk("arst up_data", 64'(up_data), 64'd0);
        chk("arst dn_data", 64'(dn_data), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        m_weight = 16'h0; m_mask = 2'b11;
        run_op("post_rst", 16'd7, 32'd40, 32'd2, 0, 1, 1, 0, 0, 1'b0, 16'h0, lat);
        chk("post_rst literal", 64'(model(16'd7, m_weight, m_mask, 32'd40, 32'd2)), 64'd42);

        // Randomized operations (sums kept small so saturation order never matters)
        for (int k = 0; k < 25; k++) begin
            logic [15:0] w, d;
            logic [31:0] a, b;
            w = 16'($urandom);
            d = 16'($urandom);
            a = 32'($signed(20'($urandom)));
            b = 32'($signed(20'($urandom)));
            cfg_write(SLV, w);
            cfg_write(SLV + 11'd1, 16'($urandom_range(0, 3)));
            run_op("rand", d, a, b, $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                   1'b0, 16'h0, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
